cache_mem_arbiter: RTL and testbench

//  Shares the single line-wide physical-memory port between the I-cache
//  (read-only) and the D-cache (read/write) miss/writeback paths in mp3.

---
 rtl/cache_mem_arbiter.sv | 87 ++++++++
 tb/tb_cache_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one line-wide memory port between I-cache and D-cache
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              grant_d
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              d_req, pick_d;
   // Grant decision in IDLE; the round-robin pointer only moves on a genuine tie
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      op_wr_d     = op_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      d_req       = d_read | d_write;
      pick_d      = d_req & (~i_read | ~last_d_q);
      if (state_q == IDLE) begin
         if (i_read | d_req) begin
            state_d     = pick_d ? SERVE_D : SERVE_I;
            last_d_d    = (i_read & d_req) ? pick_d : last_d_q;
            op_wr_d     = pick_d & d_write;
            mem_addr_d  = pick_d ? d_addr : i_addr;
            mem_wdata_d = pick_d ? d_wdata : mem_wdata_q;
         end
      end else if (mem_resp) begin
         state_d = IDLE;
      end
   end
   // State, round-robin pointer and latched transaction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         op_wr_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         op_wr_q     <= op_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end
   // Strobes come from the latched op so they stay steady until mem_resp
   always_comb begin
      mem_read  = (state_q != IDLE) & ~op_wr_q;
      mem_write = (state_q == SERVE_D) & op_wr_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      grant_d   = state_q == SERVE_D;
      i_resp    = (state_q == SERVE_I) & mem_resp;
      d_resp    = (state_q == SERVE_D) & mem_resp;
      i_rdata   = mem_rdata;
      d_rdata   = mem_rdata;
   end
   // Simulation-only flags for requester contract and port invariant
   always_ff @(posedge clk) begin
      if (!rst && d_read && d_write) $error("d_read and d_write asserted together; write wins");
      if (!rst) assert (!(mem_read && mem_write));
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed and randomized checks of cache_mem_arbiter against a transaction-level model
module tb_cache_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write, mem_resp;
   logic [31:0]  i_addr, d_addr;
   logic [255:0] d_wdata, mem_rdata;
   logic [255:0] i_rdata, d_rdata, mem_wdata;
   logic [31:0]  mem_addr;
   logic         i_resp, d_resp, mem_read, mem_write, grant_d;
   int           checks = 0;
   int           errors = 0;
   logic [255:0] mem_model [logic [31:0]];

   cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .grant_d(grant_d)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] rd(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : {8{a ^ 32'h5a5a_0000}};
   endfunction

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_read, mem_write, i_resp, d_resp, grant_d} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes got %b exp 00000", {mem_read, mem_write, i_resp, d_resp, grant_d});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin
         errors++; $display("FAIL reset_regs got addr %h wdata %h exp 0", mem_addr, mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_i_read;
      @(negedge clk);
      i_read = 1; i_addr = 32'h60;
      @(negedge clk);
      checks++;
      if (mem_read !== 1 || mem_write !== 0 || mem_addr !== 32'h60) begin
         errors++; $display("FAIL i_read_strobe got rd %b wr %b addr %h exp 1 0 60", mem_read, mem_write, mem_addr);
      end
      mem_resp = 1; mem_rdata = {32{8'hab}};
      #1;
      checks++;
      if (i_resp !== 1 || d_resp !== 0 || i_rdata !== {32{8'hab}}) begin
         errors++; $display("FAIL i_read_resp got i_resp %b d_resp %b data %h", i_resp, d_resp, i_rdata);
      end
      @(negedge clk);
      mem_resp = 0; i_read = 0;
      #1;
      checks++;
      if (mem_read !== 0 || i_resp !== 0) begin
         errors++; $display("FAIL i_read_after got rd %b resp %b exp 0 0", mem_read, i_resp);
      end
   endtask

   task automatic test_d_write;
      logic [255:0] pat;
      int           bad;
      for (int k = 0; k < 8; k++) pat[k*32 +: 32] = $urandom();
      @(negedge clk);
      d_write = 1; d_addr = 32'h1400; d_wdata = pat;
      @(negedge clk);
      checks++;
      if (mem_write !== 1 || mem_read !== 0 || mem_wdata !== pat || mem_addr !== 32'h1400 || grant_d !== 1) begin
         errors++; $display("FAIL d_write_strobe got wr %b rd %b addr %h wdata %h", mem_write, mem_read, mem_addr, mem_wdata);
      end
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (mem_write !== 1 || mem_read !== 0 || d_resp !== 0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL d_write_hold got %0d bad cycles exp 0", bad);
      end
      mem_resp = 1;
      #1;
      checks++;
      if (d_resp !== 1 || i_resp !== 0) begin
         errors++; $display("FAIL d_write_resp got d_resp %b i_resp %b exp 1 0", d_resp, i_resp);
      end
      @(negedge clk);
      mem_resp = 0; d_write = 0;
      #1;
      checks++;
      if (d_resp !== 0 || mem_write !== 0) begin
         errors++; $display("FAIL d_write_pulse got d_resp %b wr %b exp 0 0", d_resp, mem_write);
      end
   endtask

   task automatic test_tie;
      do_reset;
      i_read = 1; i_addr = 32'h80; d_read = 1; d_addr = 32'h1418;
      @(negedge clk);
      checks++;
      if (mem_read !== 1 || mem_addr !== 32'h1418 || grant_d !== 1) begin
         errors++; $display("FAIL tie1_d_first got rd %b addr %h grant_d %b exp 1 1418 1", mem_read, mem_addr, grant_d);
      end
      mem_resp = 1;
      #1;
      checks++;
      if (d_resp !== 1 || i_resp !== 0) begin
         errors++; $display("FAIL tie1_d_resp got d %b i %b exp 1 0", d_resp, i_resp);
      end
      @(negedge clk);
      mem_resp = 0; d_read = 0;
      #1;
      checks++;
      if (mem_read !== 0 || mem_write !== 0) begin
         errors++; $display("FAIL tie1_gap got rd %b wr %b exp 0 0", mem_read, mem_write);
      end
      @(negedge clk);
      checks++;
      if (mem_read !== 1 || mem_addr !== 32'h80 || grant_d !== 0) begin
         errors++; $display("FAIL tie1_i_second got rd %b addr %h grant_d %b exp 1 80 0", mem_read, mem_addr, grant_d);
      end
      mem_resp = 1;
      #1;
      checks++;
      if (i_resp !== 1 || d_resp !== 0) begin
         errors++; $display("FAIL tie1_i_resp got i %b d %b exp 1 0", i_resp, d_resp);
      end
      @(negedge clk);
      mem_resp = 0; i_addr = 32'ha0; d_read = 1; d_addr = 32'h1420;
      @(negedge clk);
      checks++;
      if (mem_read !== 1 || mem_addr !== 32'ha0 || grant_d !== 0) begin
         errors++; $display("FAIL tie2_i_first got rd %b addr %h grant_d %b exp 1 a0 0", mem_read, mem_addr, grant_d);
      end
      mem_resp = 1;
      #1;
      @(negedge clk);
      mem_resp = 0; i_read = 0;
      @(negedge clk);
      checks++;
      if (mem_read !== 1 || mem_addr !== 32'h1420 || grant_d !== 1) begin
         errors++; $display("FAIL tie2_d_second got rd %b addr %h grant_d %b exp 1 1420 1", mem_read, mem_addr, grant_d);
      end
      mem_resp = 1;
      #1;
      @(negedge clk);
      mem_resp = 0; d_read = 0;
   endtask

   task automatic test_addr_hold;
      int bad;
      @(negedge clk);
      d_read = 1; d_addr = 32'h1400;
      @(negedge clk);
      d_addr = 32'h2000;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_addr !== 32'h1400 || mem_read !== 1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL addr_hold got %0d bad cycles, addr %h exp 1400", bad, mem_addr);
      end
      mem_resp = 1;
      #1;
      checks++;
      if (d_resp !== 1 || mem_addr !== 32'h1400) begin
         errors++; $display("FAIL addr_hold_resp got d_resp %b addr %h exp 1 1400", d_resp, mem_addr);
      end
      @(negedge clk);
      mem_resp = 0; d_read = 0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      d_write = 1; d_addr = 32'h1400; d_wdata = {8{32'hdead_beef}};
      @(negedge clk);
      checks++;
      if (mem_write !== 1) begin
         errors++; $display("FAIL reset_mid_pre got wr %b exp 1", mem_write);
      end
      repeat (3) @(negedge clk);
      rst = 1; d_write = 0;
      @(negedge clk);
      checks++;
      if (mem_read !== 0 || mem_write !== 0 || grant_d !== 0 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_mid_idle got rd %b wr %b grant_d %b addr %h exp 0 0 0 0", mem_read, mem_write, grant_d, mem_addr);
      end
      rst = 0;
      @(negedge clk);
      mem_resp = 1;
      #1;
      checks++;
      if (i_resp !== 0 || d_resp !== 0) begin
         errors++; $display("FAIL stray_resp got i %b d %b exp 0 0", i_resp, d_resp);
      end
      @(negedge clk);
      mem_resp = 0;
      #1;
      checks++;
      if (mem_read !== 0 || mem_write !== 0) begin
         errors++; $display("FAIL stray_resp_after got rd %b wr %b exp 0 0", mem_read, mem_write);
      end
   endtask

   task automatic test_random;
      int           owner, cnt, txns, cycles, i_wait, d_wait;
      bit           last_d, i_pend, d_pend, d_w, lw, pick_d;
      logic [31:0]  la;
      logic [255:0] lwd, exp_data;
      do_reset;
      owner = 0; cnt = 0; txns = 0; cycles = 0; i_wait = 0; d_wait = 0;
      last_d = 0; i_pend = 0; d_pend = 0; d_w = 0; lw = 0; la = 0; lwd = 0; exp_data = 0;
      while ((txns < 3000 || owner != 0 || i_pend || d_pend) && cycles < 30000) begin
         @(negedge clk);
         cycles++;
         if (!i_pend && txns < 3000 && $urandom_range(0, 3) == 0) begin
            i_pend = 1; i_addr = 32'($urandom_range(0, 15)) << 5;
         end
         if (!d_pend && txns < 3000 && $urandom_range(0, 3) == 0) begin
            d_pend = 1; d_w = 1'($urandom_range(0, 1));
            d_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 5);
            for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom();
         end
         i_read = i_pend; d_read = d_pend & ~d_w; d_write = d_pend & d_w;
         checks++;
         if (mem_read !== (owner != 0 && !lw) || mem_write !== (owner != 0 && lw) || grant_d !== (owner == 2)) begin
            errors++; $display("FAIL rand_strobe cyc %0d got rd %b wr %b gd %b exp owner %0d write %b", cycles, mem_read, mem_write, grant_d, owner, lw);
         end
         if (owner != 0) begin
            checks++;
            if (mem_addr !== la || (lw && mem_wdata !== lwd)) begin
               errors++; $display("FAIL rand_addr cyc %0d got %h exp %h", cycles, mem_addr, la);
            end
         end
         if (owner != 0 && cnt == 0) begin
            mem_resp = 1;
            exp_data = lw ? {8{$urandom()}} : rd(la);
            mem_rdata = exp_data;
         end else begin
            mem_resp = (owner == 0) && $urandom_range(0, 3) == 0;
            mem_rdata = {8{$urandom()}};
            if (owner != 0) cnt--;
         end
         #1;
         checks++;
         if (i_resp !== (mem_resp && owner == 1) || d_resp !== (mem_resp && owner == 2)) begin
            errors++; $display("FAIL rand_resp cyc %0d got i %b d %b exp owner %0d mem_resp %b", cycles, i_resp, d_resp, owner, mem_resp);
         end
         if (owner != 0 && mem_resp && !lw) begin
            checks++;
            if ((owner == 1 ? i_rdata : d_rdata) !== exp_data) begin
               errors++; $display("FAIL rand_rdata cyc %0d addr %h exp %h", cycles, la, exp_data);
            end
         end
         if (owner != 0) begin
            if (mem_resp) begin
               if (lw) mem_model[la] = lwd;
               if (owner == 1) i_pend = 0; else d_pend = 0;
               txns++;
               owner = 0;
            end
         end else if (i_pend || d_pend) begin
            pick_d = d_pend && (!i_pend || !last_d);
            if (i_pend && d_pend) last_d = pick_d;
            owner = pick_d ? 2 : 1;
            la = pick_d ? d_addr : i_addr;
            lw = pick_d && d_w;
            lwd = d_wdata;
            cnt = $urandom_range(0, 3);
            checks++;
            if ((pick_d ? d_wait : i_wait) > 1) begin
               errors++; $display("FAIL rand_fair cyc %0d side %0d waited %0d exp <=1", cycles, owner, pick_d ? d_wait : i_wait);
            end
            if (pick_d) begin d_wait = 0; if (i_pend) i_wait++; end
            else begin i_wait = 0; if (d_pend) d_wait++; end
         end
      end
      checks++;
      if (cycles >= 30000) begin
         errors++; $display("FAIL rand_timeout got %0d txns in %0d cycles exp 3000", txns, cycles);
      end
      @(negedge clk);
      i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
   endtask

   initial begin
      test_reset;
      test_i_read;
      test_d_write;
      test_tie;
      test_addr_hold;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
